bullet_pool: RTL and testbench

//  Multi-slot player-bullet manager. Generalises the single-bullet scheme to NUM_BULLETS concurrent shots.

---
 rtl/bullet_pool.sv | 197 +++++++++++++++++++
 tb/tb_bullet_pool.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// bullet_pool: pool of NUM_BULLETS player shots. Fire allocates the lowest free slot, each frame moves shots up, and a hit or leaving the top edge retires a shot. The block also draws a pixel overlay.
// Latency: fire_ack and slot state update 1 cycle after fire_req; pix_on/pix_color 1 cycle after hcount/vcount; active_mask/bx_flat/by_flat are direct register outputs.
// Backpressure: none. A shot is dropped with no ack when it cannot be accepted (cooldown running, pool full, or fire_y too close to the top). The requester holds or re-issues fire_req.
// Ports: clk/rst (async, active-high); frame_tick; fire_req/fire_x/fire_y -> fire_ack;
//        hit_valid/hit_id; hcount/vcount -> pix_on/pix_color; active_mask, bx_flat, by_flat;
//        shots_fired/shots_hit (live only when BULLET_POOL_STATS_EN is defined, otherwise 16'h0).
module bullet_pool #(
    parameter int          NUM_BULLETS  = 4,
    parameter int          HRES         = 1280,
    parameter int          VRES         = 720,
    parameter int          XW           = 11,
    parameter int          YW           = 10,
    parameter int          BULLET_W     = 4,
    parameter int          BULLET_H     = 16,
    parameter int          BULLET_SPEED = 16,
    parameter int          COOLDOWN     = 8,
    parameter logic [23:0] COLOR        = 24'hFFFFFF,
    parameter int          IDW          = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_tick,
    input  logic                      fire_req,
    input  logic [XW-1:0]             fire_x,
    input  logic [YW-1:0]             fire_y,
    output logic                      fire_ack,
    input  logic                      hit_valid,
    input  logic [IDW-1:0]            hit_id,
    input  logic [XW-1:0]             hcount,
    input  logic [YW-1:0]             vcount,
    output logic                      pix_on,
    output logic [23:0]               pix_color,
    output logic [NUM_BULLETS-1:0]    active_mask,
    output logic [NUM_BULLETS*XW-1:0] bx_flat,
    output logic [NUM_BULLETS*YW-1:0] by_flat,
    output logic [15:0]               shots_fired,
    output logic [15:0]               shots_hit
);

    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int XE = XW + 1;
    localparam int YE = YW + 1;

    // Catch configurations that cannot address the screen or the slot pool.
    if (NUM_BULLETS < 1) begin : g_chk_num
        $error("bullet_pool: NUM_BULLETS must be >= 1");
    end
    if ((2 ** XW) < HRES || (2 ** YW) < VRES) begin : g_chk_res
        $error("bullet_pool: XW/YW too narrow for HRES/VRES");
    end
    if ((2 ** IDW) < NUM_BULLETS) begin : g_chk_idw
        $error("bullet_pool: IDW too narrow for NUM_BULLETS");
    end

    logic [NUM_BULLETS-1:0] active_q, active_d;
    logic [XW-1:0]          bx_q [NUM_BULLETS];
    logic [XW-1:0]          bx_d [NUM_BULLETS];
    logic [YW-1:0]          by_q [NUM_BULLETS];
    logic [YW-1:0]          by_d [NUM_BULLETS];
    logic [CW-1:0]          cool_q, cool_d;
    logic                   free_found;
    logic [IDW-1:0]         free_idx;
    logic                   fire_ok;
    logic                   pix_hit;

    // Lowest-index free slot. The search uses the registered mask, so a slot
    // retired by a hit in this cycle only becomes allocatable next cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDW'(i);
            end
        end
    end

    assign fire_ok = fire_req && (cool_q == '0) && free_found && (fire_y >= YW'(BULLET_H));

    // Next-state: frame motion first, then a hit overrides (hit wins over
    // retirement-by-motion), then allocation writes an IDLE slot. That slot
    // was not moved by this tick, and a hit on it was ignored because it was idle.
    always_comb begin
        active_d = active_q;
        bx_d     = bx_q;
        by_d     = by_q;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (frame_tick && active_q[i]) begin
                if (by_q[i] < YW'(BULLET_SPEED)) begin
                    active_d[i] = 1'b0;
                end else begin
                    by_d[i] = by_q[i] - YW'(BULLET_SPEED);
                end
            end
            if (hit_valid && (hit_id == IDW'(i))) begin
                active_d[i] = 1'b0;
            end
            if (fire_ok && (free_idx == IDW'(i))) begin
                active_d[i] = 1'b1;
                bx_d[i]     = fire_x;
                by_d[i]     = fire_y - YW'(BULLET_H);
            end
        end
    end

    // Cooldown: a load on accept takes priority over the per-frame decrement.
    always_comb begin
        cool_d = cool_q;
        if (fire_ok) begin
            cool_d = CW'(COOLDOWN);
        end else if (frame_tick && (cool_q != '0)) begin
            cool_d = cool_q - CW'(1);
        end
    end

    // Output logic: pixel coverage. Compares are one bit wider than the
    // coordinates so that a bullet near the right or bottom edge cannot wrap.
    always_comb begin
        pix_hit = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (active_q[i]
                && ({1'b0, hcount} >= {1'b0, bx_q[i]})
                && ({1'b0, hcount} <  ({1'b0, bx_q[i]} + XE'(BULLET_W)))
                && ({1'b0, vcount} >= {1'b0, by_q[i]})
                && ({1'b0, vcount} <  ({1'b0, by_q[i]} + YE'(BULLET_H)))) begin
                pix_hit = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q  <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                bx_q[i] <= '0;
                by_q[i] <= '0;
            end
            cool_q    <= '0;
            fire_ack  <= 1'b0;
            pix_on    <= 1'b0;
            pix_color <= '0;
        end else begin
            active_q  <= active_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            cool_q    <= cool_d;
            fire_ack  <= fire_ok;
            pix_on    <= pix_hit;
            pix_color <= pix_hit ? COLOR : 24'h0;
        end
    end

    assign active_mask = active_q;

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_flat
        assign bx_flat[g*XW +: XW] = bx_q[g];
        assign by_flat[g*YW +: YW] = by_q[g];
    end

`ifdef BULLET_POOL_STATS_EN
    logic        hit_real;
    logic [15:0] fired_q, hitcnt_q;

    // Only hits that actually retire a live slot are counted.
    always_comb begin
        hit_real = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (hit_valid && (hit_id == IDW'(i)) && active_q[i]) begin
                hit_real = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fired_q  <= '0;
            hitcnt_q <= '0;
        end else begin
            if (fire_ok && (fired_q != 16'hFFFF)) begin
                fired_q <= fired_q + 16'd1;
            end
            if (hit_real && (hitcnt_q != 16'hFFFF)) begin
                hitcnt_q <= hitcnt_q + 16'd1;
            end
        end
    end

    assign shots_fired = fired_q;
    assign shots_hit   = hitcnt_q;
`else
    assign shots_fired = 16'h0;
    assign shots_hit   = 16'h0;
`endif

endmodule

// File: tb/tb_bullet_pool.sv
module tb_bullet_pool;

    localparam int N   = 4;
    localparam int XW  = 11;
    localparam int YW  = 10;
    localparam int IDW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            frame_tick = 1'b0;
    logic            fire_req   = 1'b0;
    logic            fire_req8  = 1'b0;
    logic [XW-1:0]   fire_x     = '0;
    logic [YW-1:0]   fire_y     = '0;
    logic            hit_valid  = 1'b0;
    logic [IDW-1:0]  hit_id     = '0;
    logic [XW-1:0]   hcount     = '0;
    logic [YW-1:0]   vcount     = '0;

    logic            fire_ack, pix_on;
    logic [23:0]     pix_color;
    logic [N-1:0]    active_mask;
    logic [N*XW-1:0] bx_flat;
    logic [N*YW-1:0] by_flat;
    logic [15:0]     shots_fired, shots_hit;

    logic            fire_ack8, pix_on8;
    logic [23:0]     pix_color8;
    logic [N-1:0]    active_mask8;
    logic [N*XW-1:0] bx_flat8;
    logic [N*YW-1:0] by_flat8;
    logic [15:0]     shots_fired8, shots_hit8;

    bullet_pool #(.NUM_BULLETS(N), .XW(XW), .YW(YW), .COOLDOWN(0), .IDW(IDW)) dut0 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .fire_req(fire_req), .fire_x(fire_x), .fire_y(fire_y), .fire_ack(fire_ack),
        .hit_valid(hit_valid), .hit_id(hit_id), .hcount(hcount), .vcount(vcount),
        .pix_on(pix_on), .pix_color(pix_color), .active_mask(active_mask),
        .bx_flat(bx_flat), .by_flat(by_flat), .shots_fired(shots_fired), .shots_hit(shots_hit)
    );

    bullet_pool #(.NUM_BULLETS(N), .XW(XW), .YW(YW), .COOLDOWN(8), .IDW(IDW)) dut8 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .fire_req(fire_req8), .fire_x(fire_x), .fire_y(fire_y), .fire_ack(fire_ack8),
        .hit_valid(hit_valid), .hit_id(hit_id), .hcount(hcount), .vcount(vcount),
        .pix_on(pix_on8), .pix_color(pix_color8), .active_mask(active_mask8),
        .bx_flat(bx_flat8), .by_flat(by_flat8), .shots_fired(shots_fired8), .shots_hit(shots_hit8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int slot;
        int x;
        int y;
    } fire_exp_t;

    fire_exp_t ack_q[$];
    logic      pix_q[$];
    int        cd_q[$];

    function automatic logic [XW-1:0] slot_x(input int i);
        return bx_flat[i*XW +: XW];
    endfunction

    function automatic logic [YW-1:0] slot_y(input int i);
        return by_flat[i*YW +: YW];
    endfunction

    function automatic logic [15:0] stat(input int n);
`ifdef BULLET_POOL_STATS_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    // One cycle of stimulus on dut0; fire acks are matched against the scoreboard.
    task automatic drive_cycle(input logic f, input int x, input int y,
                               input logic t, input logic hv, input int hid);
        fire_exp_t e;
        fire_req   = f;
        fire_x     = XW'(x);
        fire_y     = YW'(y);
        frame_tick = t;
        hit_valid  = hv;
        hit_id     = IDW'(hid);
        @(negedge clk);
        fire_req   = 1'b0;
        frame_tick = 1'b0;
        hit_valid  = 1'b0;
        if (fire_ack) begin
            n_checks++;
            if (ack_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: fire_ack=1, required 0");
            end else begin
                e = ack_q.pop_front();
                if (active_mask[e.slot] !== 1'b1 || slot_x(e.slot) !== XW'(e.x) || slot_y(e.slot) !== YW'(e.y)) begin
                    n_fail++;
                    $display("FAIL ack_slot%0d: active=%b x=%0d y=%0d, required active=1 x=%0d y=%0d",
                             e.slot, active_mask[e.slot], slot_x(e.slot), slot_y(e.slot), e.x, e.y);
                end
            end
        end else if (ack_q.size() != 0) begin
            n_checks++;
            n_fail++;
            e = ack_q.pop_front();
            $display("FAIL missing_ack: fire_ack=0, required ack for slot %0d", e.slot);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++; if (active_mask !== '0)   begin n_fail++; $display("FAIL rst_mask: got %h, required 0", active_mask); end
        n_checks++; if (fire_ack !== 1'b0)    begin n_fail++; $display("FAIL rst_ack: got %b, required 0", fire_ack); end
        n_checks++; if (pix_on !== 1'b0 || pix_color !== 24'h0) begin n_fail++; $display("FAIL rst_pix: got %b/%h, required 0/0", pix_on, pix_color); end
        n_checks++; if (bx_flat !== '0 || by_flat !== '0) begin n_fail++; $display("FAIL rst_xy: got %h/%h, required 0/0", bx_flat, by_flat); end
        n_checks++; if (shots_fired !== 16'h0 || shots_hit !== 16'h0) begin n_fail++; $display("FAIL rst_stats: got %0d/%0d, required 0/0", shots_fired, shots_hit); end
        n_checks++; if (active_mask8 !== '0)  begin n_fail++; $display("FAIL rst_mask8: got %h, required 0", active_mask8); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fire_single;
        ack_q.push_back('{0, 600, 664});
        drive_cycle(1, 600, 680, 0, 0, 0);
        n_checks++; if (active_mask !== 4'b0001) begin n_fail++; $display("FAIL single_mask: got %b, required 0001", active_mask); end
        drive_cycle(0, 0, 0, 0, 0, 0);
        n_checks++; if (fire_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b, required 0", fire_ack); end
    endtask

    task automatic test_fill;
        ack_q.push_back('{1, 610, 664});
        drive_cycle(1, 610, 680, 0, 0, 0);
        ack_q.push_back('{2, 620, 384});
        drive_cycle(1, 620, 400, 0, 0, 0);
        ack_q.push_back('{3, 630, 284});
        drive_cycle(1, 630, 300, 0, 0, 0);
        drive_cycle(1, 640, 680, 0, 0, 0);
        n_checks++; if (fire_ack !== 1'b0)     begin n_fail++; $display("FAIL full_ack: got %b, required 0", fire_ack); end
        n_checks++; if (active_mask !== 4'hF)  begin n_fail++; $display("FAIL full_mask: got %h, required F", active_mask); end
        n_checks++; if (shots_fired !== stat(4)) begin n_fail++; $display("FAIL fill_fired: got %0d, required %0d", shots_fired, stat(4)); end
    endtask

    task automatic test_hit;
        drive_cycle(0, 0, 0, 1, 1, 1);
        n_checks++; if (active_mask !== 4'b1101) begin n_fail++; $display("FAIL hit_tick_mask: got %b, required 1101", active_mask); end
        n_checks++; if (slot_y(0) !== YW'(648) || slot_y(3) !== YW'(268)) begin n_fail++; $display("FAIL hit_tick_move: got y0=%0d y3=%0d, required 648/268", slot_y(0), slot_y(3)); end
        n_checks++; if (shots_hit !== stat(1)) begin n_fail++; $display("FAIL hit_count: got %0d, required %0d", shots_hit, stat(1)); end
        drive_cycle(0, 0, 0, 0, 1, 5);
        n_checks++; if (active_mask !== 4'b1101) begin n_fail++; $display("FAIL hit_oob: got %b, required 1101", active_mask); end
        drive_cycle(0, 0, 0, 0, 1, 1);
        n_checks++; if (active_mask !== 4'b1101 || shots_hit !== stat(1)) begin n_fail++; $display("FAIL hit_idle: got %b/%0d, required 1101/%0d", active_mask, shots_hit, stat(1)); end
    endtask

    task automatic test_fire_hit_same_cycle;
        ack_q.push_back('{1, 700, 484});
        drive_cycle(1, 700, 500, 0, 0, 0);
        n_checks++; if (active_mask !== 4'hF) begin n_fail++; $display("FAIL refill_mask: got %h, required F", active_mask); end
        drive_cycle(1, 710, 500, 0, 1, 2);
        n_checks++; if (fire_ack !== 1'b0 || active_mask !== 4'b1011) begin n_fail++; $display("FAIL fire_hit: got ack=%b mask=%b, required 0/1011", fire_ack, active_mask); end
        n_checks++; if (shots_hit !== stat(2)) begin n_fail++; $display("FAIL fire_hit_count: got %0d, required %0d", shots_hit, stat(2)); end
        ack_q.push_back('{2, 720, 84});
        drive_cycle(1, 720, 100, 1, 0, 0);
        n_checks++; if (active_mask !== 4'hF) begin n_fail++; $display("FAIL fire_tick_mask: got %h, required F", active_mask); end
        n_checks++; if (slot_y(0) !== YW'(632) || slot_y(1) !== YW'(468) || slot_y(3) !== YW'(252)) begin n_fail++; $display("FAIL fire_tick_move: got %0d/%0d/%0d, required 632/468/252", slot_y(0), slot_y(1), slot_y(3)); end
        n_checks++; if (shots_fired !== stat(6)) begin n_fail++; $display("FAIL fire_tick_fired: got %0d, required %0d", shots_fired, stat(6)); end
    endtask

    task automatic test_fire_y_boundary;
        drive_cycle(0, 0, 0, 0, 1, 3);
        n_checks++; if (active_mask !== 4'b0111) begin n_fail++; $display("FAIL free3_mask: got %b, required 0111", active_mask); end
        drive_cycle(1, 730, 10, 0, 0, 0);
        n_checks++; if (fire_ack !== 1'b0 || active_mask !== 4'b0111) begin n_fail++; $display("FAIL low_y: got ack=%b mask=%b, required 0/0111", fire_ack, active_mask); end
        ack_q.push_back('{3, 730, 0});
        drive_cycle(1, 730, 16, 0, 0, 0);
        drive_cycle(0, 0, 0, 1, 0, 0);
        n_checks++; if (active_mask !== 4'b0111 || slot_y(2) !== YW'(68)) begin n_fail++; $display("FAIL top_retire: got mask=%b y2=%0d, required 0111/68", active_mask, slot_y(2)); end
        n_checks++; if (shots_fired !== stat(7) || shots_hit !== stat(3)) begin n_fail++; $display("FAIL stats: got %0d/%0d, required %0d/%0d", shots_fired, shots_hit, stat(7), stat(3)); end
    endtask

    task automatic test_reset_midflight;
        hcount = XW'(721);
        vcount = YW'(70);
        @(negedge clk);
        n_checks++; if (pix_on !== 1'b1) begin n_fail++; $display("FAIL pre_rst_pix: got %b, required 1", pix_on); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (active_mask !== '0 || pix_on !== 1'b0 || pix_color !== 24'h0) begin n_fail++; $display("FAIL async_rst: got mask=%b pix=%b/%h, required 0/0/0", active_mask, pix_on, pix_color); end
        n_checks++; if (shots_fired !== 16'h0 || shots_hit !== 16'h0) begin n_fail++; $display("FAIL async_rst_stats: got %0d/%0d, required 0/0", shots_fired, shots_hit); end
        @(negedge clk);
        rst    = 1'b0;
        hcount = '0;
        vcount = '0;
        @(negedge clk);
    endtask

    task automatic test_retire;
        ack_q.push_back('{0, 600, 664});
        drive_cycle(1, 600, 680, 0, 0, 0);
        for (int i = 0; i < 41; i++) drive_cycle(0, 0, 0, 1, 0, 0);
        n_checks++; if (active_mask !== 4'b0001 || slot_y(0) !== YW'(8)) begin n_fail++; $display("FAIL tick41: got mask=%b y=%0d, required 0001/8", active_mask, slot_y(0)); end
        drive_cycle(0, 0, 0, 1, 0, 0);
        n_checks++; if (active_mask !== 4'b0000) begin n_fail++; $display("FAIL tick42: got mask=%b, required 0000", active_mask); end
    endtask

    task automatic test_pixel;
        int  th [9] = '{103, 104, 100,  99, 103, 100, 2047,   0, 2046};
        int  tv [9] = '{215, 215, 200, 200, 216, 199,  205, 205,  215};
        logic te [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic e;
        ack_q.push_back('{0, 100, 200});
        drive_cycle(1, 100, 216, 0, 0, 0);
        ack_q.push_back('{1, 2046, 200});
        drive_cycle(1, 2046, 216, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            hcount = XW'(th[i]);
            vcount = YW'(tv[i]);
            pix_q.push_back(te[i]);
            @(negedge clk);
            e = pix_q.pop_front();
            n_checks++;
            if (pix_on !== e || pix_color !== (e ? 24'hFFFFFF : 24'h0)) begin
                n_fail++;
                $display("FAIL pix_%0d_%0d: got %b/%h, required %b/%h", th[i], tv[i], pix_on, pix_color, e, (e ? 24'hFFFFFF : 24'h0));
            end
        end
        hcount = '0;
        vcount = '0;
    endtask

    task automatic test_cooldown;
        int ticks = 0;
        int got;
        cd_q = '{0, 8, 16, 24};
        fire_x    = XW'(50);
        fire_y    = YW'(700);
        fire_req8 = 1'b1;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            if (frame_tick) ticks++;
            frame_tick = (c % 4 == 3);
            if (fire_ack8) begin
                n_checks++;
                if (cd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cd_extra_ack: ack at tick %0d, required none", ticks);
                end else begin
                    got = cd_q.pop_front();
                    if (got != ticks) begin
                        n_fail++;
                        $display("FAIL cd_ack_tick: ack at tick %0d, required tick %0d", ticks, got);
                    end
                end
            end
        end
        fire_req8  = 1'b0;
        frame_tick = 1'b0;
        n_checks++; if (cd_q.size() != 0) begin n_fail++; $display("FAIL cd_missing: %0d acks outstanding, required 0", cd_q.size()); end
        n_checks++; if (active_mask8 !== 4'hF) begin n_fail++; $display("FAIL cd_mask: got %h, required F", active_mask8); end
    endtask

    initial begin
        test_reset;
        test_fire_single;
        test_fill;
        test_hit;
        test_fire_hit_same_cycle;
        test_fire_y_boundary;
        test_reset_midflight;
        test_retire;
        test_pixel;
        test_cooldown;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
